// File: rtl/vram_write_sched_if.sv
// Host single-pixel write stream into the VRAM write scheduler.
// master drives valid/addr/data; slave answers with ready.
interface vram_write_sched_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 24
);
  logic              host_valid;
  logic              host_ready;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_data;

  modport master (
    output host_valid,
    output host_addr,
    output host_data,
    input  host_ready
  );

  modport slave (
    input  host_valid,
    input  host_addr,
    input  host_data,
    output host_ready
  );
endinterface

// File: rtl/vram_write_sched.sv
// VRAM write-port owner: arbitrates host pixel writes against a rect-fill engine.
// Ports: CLOCK_50/RESET_N, host (if slave), fill_* operands/status, vram_* write port.
// Optional macro VRAM_FILL_CLIP_EN clips the fill rectangle to the framebuffer.
module vram_write_sched #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 24,
  parameter int COORD_W = 9,
  parameter int FB_W    = 256,
  parameter int FB_H    = 256
) (
  input  logic               CLOCK_50,
  input  logic               RESET_N,
  vram_write_sched_if.slave  host,
  input  logic               fill_start,
  input  logic [COORD_W-1:0] fill_x0,
  input  logic [COORD_W-1:0] fill_y0,
  input  logic [COORD_W-1:0] fill_w,
  input  logic [COORD_W-1:0] fill_h,
  input  logic [DATA_W-1:0]  fill_color,
  output logic               fill_busy,
  output logic               fill_done,
  output logic [ADDR_W-1:0]  vram_wadr,
  output logic [DATA_W-1:0]  vram_d,
  output logic               vram_we
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

  localparam logic G_HOST = 1'b0;
  localparam logic G_FILL = 1'b1;

  state_t             state;
  logic               last_grant;
  logic               empty_q;
  logic [COORD_W-1:0] x0_q;
  logic [COORD_W-1:0] w_q;
  logic [COORD_W-1:0] h_q;
  logic [DATA_W-1:0]  color_q;
  logic [ADDR_W-1:0]  row_base;
  logic [COORD_W-1:0] x_cnt;
  logic [COORD_W-1:0] y_cnt;

  logic               fill_req;
  logic               host_req;
  logic               gnt_host;
  logic               gnt_fill;
  logic               x_last;
  logic               y_last;
  logic [ADDR_W-1:0]  fill_addr;
  logic [ADDR_W-1:0]  base0;

  logic [COORD_W-1:0] eff_w;
  logic [COORD_W-1:0] eff_h;
  logic               acc_empty;

  assign fill_req = (state == FILL) && !empty_q;
  // ready must drop during reset even if the host keeps valid high
  assign host_req = host.host_valid && RESET_N;

  // both requesting: the one not served last time wins
  assign gnt_host = host_req &&
                    (!fill_req || last_grant == G_FILL);
  assign gnt_fill = fill_req &&
                    (!host_req || last_grant == G_HOST);

  assign host.host_ready = gnt_host;

  assign x_last = (x_cnt == w_q - COORD_W'(1));
  assign y_last = (y_cnt == h_q - COORD_W'(1));

  assign fill_addr = row_base
                   + ADDR_W'(x0_q)
                   + ADDR_W'(x_cnt);

  assign base0 = ADDR_W'(fill_y0 * FB_W);

`ifdef VRAM_FILL_CLIP_EN
  int rx;
  int ry;

  always_comb begin
    rx    = FB_W - int'(fill_x0);
    ry    = FB_H - int'(fill_y0);
    eff_w = '0;
    eff_h = '0;
    if (rx > 0 && ry > 0) begin
      eff_w = (int'(fill_w) > rx) ?
              COORD_W'(rx) : fill_w;
      eff_h = (int'(fill_h) > ry) ?
              COORD_W'(ry) : fill_h;
    end
  end
`else
  assign eff_w = fill_w;
  assign eff_h = fill_h;
`endif

  assign acc_empty = (eff_w == '0) || (eff_h == '0);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      last_grant <= G_FILL;
      empty_q    <= 1'b0;
      x0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      row_base   <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      fill_busy  <= 1'b0;
      fill_done  <= 1'b0;
      vram_wadr  <= '0;
      vram_d     <= '0;
      vram_we    <= 1'b0;
    end else begin
      vram_we   <= 1'b0;
      fill_done <= 1'b0;

      if (gnt_host) begin
        vram_we    <= 1'b1;
        vram_wadr  <= host.host_addr;
        vram_d     <= host.host_data;
        last_grant <= G_HOST;
      end else if (gnt_fill) begin
        vram_we    <= 1'b1;
        vram_wadr  <= fill_addr;
        vram_d     <= color_q;
        last_grant <= G_FILL;
      end

      unique case (state)
        IDLE: begin
          if (fill_start) begin
            state     <= FILL;
            fill_busy <= 1'b1;
            empty_q   <= acc_empty;
            x0_q      <= fill_x0;
            w_q       <= eff_w;
            h_q       <= eff_h;
            color_q   <= fill_color;
            row_base  <= base0;
            x_cnt     <= '0;
            y_cnt     <= '0;
          end
        end
        FILL: begin
          if (empty_q) begin
            state     <= DONE;
            fill_busy <= 1'b0;
            fill_done <= 1'b1;
          end else if (gnt_fill) begin
            if (x_last) begin
              x_cnt <= '0;
              if (y_last) begin
                state     <= DONE;
                fill_busy <= 1'b0;
                fill_done <= 1'b1;
              end else begin
                y_cnt    <= y_cnt + COORD_W'(1);
                row_base <= row_base
                          + ADDR_W'(FB_W);
              end
            end else begin
              x_cnt <= x_cnt + COORD_W'(1);
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_write_sched.sv
// Scoreboard bench for vram_write_sched.
// Expected writes are queued at stimulus time and popped on vram_we.
module tb_vram_write_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fill_start = 1'b0;
  logic [8:0]  fill_x0 = '0;
  logic [8:0]  fill_y0 = '0;
  logic [8:0]  fill_w = '0;
  logic [8:0]  fill_h = '0;
  logic [23:0] fill_color = '0;
  logic        fill_busy;
  logic        fill_done;
  logic [15:0] vram_wadr;
  logic [23:0] vram_d;
  logic        vram_we;

  vram_write_sched_if #(.ADDR_W(16), .DATA_W(24)) hif ();

  vram_write_sched dut (
    .CLOCK_50   (clk),
    .RESET_N    (rst_n),
    .host       (hif),
    .fill_start (fill_start),
    .fill_x0    (fill_x0),
    .fill_y0    (fill_y0),
    .fill_w     (fill_w),
    .fill_h     (fill_h),
    .fill_color (fill_color),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .vram_wadr  (vram_wadr),
    .vram_d     (vram_d),
    .vram_we    (vram_we)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [23:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t fq[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  n_wr = 0;

  task automatic check(string tag,
                       logic [63:0] obs,
                       logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    wr_t e;
    if (vram_we) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        check("spurious_we", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("wadr", 64'(vram_wadr), 64'(e.a));
        check("wdata", 64'(vram_d), 64'(e.d));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build_fill(int x0, int y0,
                            int w, int h,
                            logic [23:0] c);
    int ew;
    int eh;
    wr_t e;
    ew = w;
    eh = h;
`ifdef VRAM_FILL_CLIP_EN
    if (x0 >= 256 || y0 >= 256) begin
      ew = 0;
    end else begin
      if (ew > 256 - x0) ew = 256 - x0;
      if (eh > 256 - y0) eh = 256 - y0;
    end
`endif
    fq.delete();
    for (int yy = 0; yy < eh; yy++)
      for (int xx = 0; xx < ew; xx++) begin
        e.a = 16'((y0 + yy) * 256 + x0 + xx);
        e.d = c;
        fq.push_back(e);
      end
  endtask

  task automatic pulse_start(int x0, int y0,
                             int w, int h,
                             logic [23:0] c);
    fill_x0    = 9'(x0);
    fill_y0    = 9'(y0);
    fill_w     = 9'(w);
    fill_h     = 9'(h);
    fill_color = c;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
  endtask

  task automatic run_fill(string tag,
                          int x0, int y0,
                          int w, int h,
                          logic [23:0] c,
                          bit with_host,
                          int exp_busy);
    int  busy;
    int  done;
    int  nh;
    int  nh_exp;
    int  w0;
    bit  hs;
    wr_t e;
    build_fill(x0, y0, w, h, c);
    nh_exp = with_host ? fq.size() : 0;
    for (int i = 0; i < fq.size(); i++) begin
      if (with_host) begin
        e.a = 16'hF000 + 16'(i);
        e.d = 24'hA00000 + 24'(i);
        exp_q.push_back(e);
      end
      exp_q.push_back(fq[i]);
    end
    w0 = n_wr;
    busy = 0;
    done = 0;
    nh = 0;
    pulse_start(x0, y0, w, h, c);
    if (nh_exp > 0) begin
      hif.host_valid = 1'b1;
      hif.host_addr  = 16'hF000;
      hif.host_data  = 24'hA00000;
    end
    for (int k = 0; k < 200 && done == 0; k++) begin
      @(negedge clk);
      if (fill_busy) busy++;
      if (fill_done) done++;
      hs = hif.host_valid && hif.host_ready;
      tick();
      if (hs) begin
        nh++;
        if (nh < nh_exp) begin
          hif.host_addr = 16'hF000 + 16'(nh);
          hif.host_data = 24'hA00000 + 24'(nh);
        end else begin
          hif.host_valid = 1'b0;
        end
      end
    end
    hif.host_valid = 1'b0;
    @(negedge clk);
    check({tag, "_done_once"}, 64'(fill_done), 0);
    tick();
    tick();
    check({tag, "_done"}, 64'(done), 1);
    check({tag, "_busy_cyc"}, 64'(busy), 64'(exp_busy));
    check({tag, "_host_n"}, 64'(nh), 64'(nh_exp));
    check({tag, "_nwr"}, 64'(n_wr - w0),
          64'(fq.size() + nh_exp));
    check({tag, "_q_left"}, 64'(exp_q.size()), 0);
  endtask

  initial begin : stim
    int  w0;
    int  done;
    wr_t e;
    hif.host_valid = 1'b1;
    hif.host_addr  = 16'h5555;
    hif.host_data  = 24'h123456;
    #12;
    check("rst_we", 64'(vram_we), 0);
    check("rst_wadr", 64'(vram_wadr), 0);
    check("rst_d", 64'(vram_d), 0);
    check("rst_busy", 64'(fill_busy), 0);
    check("rst_done", 64'(fill_done), 0);
    check("rst_ready", 64'(hif.host_ready), 0);
    hif.host_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // single host write, fill idle
    w0 = n_wr;
    hif.host_valid = 1'b1;
    hif.host_addr  = 16'h1234;
    hif.host_data  = 24'hABCDEF;
    #1;
    check("host_ready", 64'(hif.host_ready), 1);
    e.a = 16'h1234;
    e.d = 24'hABCDEF;
    exp_q.push_back(e);
    tick();
    hif.host_valid = 1'b0;
    tick();
    tick();
    check("host_nwr", 64'(n_wr - w0), 1);

    run_fill("fill", 2, 3, 4, 2,
             24'h00FF00, 1'b0, 8);
    run_fill("mix", 2, 3, 4, 2,
             24'h00FF00, 1'b1, 16);
    run_fill("w0", 5, 5, 0, 5,
             24'h0000FF, 1'b0, 1);
`ifdef VRAM_FILL_CLIP_EN
    run_fill("clip", 254, 0, 4, 1,
             24'hFF0000, 1'b0, 2);
`else
    run_fill("spill", 254, 0, 4, 1,
             24'hFF0000, 1'b0, 4);
`endif

    // reset after the third fill write
    build_fill(10, 20, 4, 2, 24'h00AA00);
    for (int i = 0; i < 3; i++)
      exp_q.push_back(fq[i]);
    w0 = n_wr;
    pulse_start(10, 20, 4, 2, 24'h00AA00);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      #1;
      if (n_wr - w0 >= 3) break;
    end
    check("rst_mid_nwr", 64'(n_wr - w0), 3);
    rst_n = 1'b0;
    hif.host_valid = 1'b1;
    #1;
    check("rstm_we", 64'(vram_we), 0);
    check("rstm_wadr", 64'(vram_wadr), 0);
    check("rstm_d", 64'(vram_d), 0);
    check("rstm_busy", 64'(fill_busy), 0);
    check("rstm_ready", 64'(hif.host_ready), 0);
    hif.host_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    done = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (fill_done) done++;
    end
    check("rstm_no_done", 64'(done), 0);
    check("rstm_no_wr", 64'(n_wr - w0), 3);
    check("rstm_q_left", 64'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
